wbu_pipe: RTL and testbench
===========================

// Module: wbu_pipe
// PURPOSE
//   Registered, multi-lane writeback stage. It sits between the MEM stage and the register file.
//   - Holds one issue bundle of LANES lanes.
//   - Per lane, selects ALU result or load data, and sign/zero-extends loads.
//   - Stalls upstream while waiting for late memory read data.
//   - Drives one regfile write port per lane, with same-cycle write-after-write masking.
// PARAMETERS
//   LANES   2  issue lanes per bundle; lane 0 is the only lane allowed to carry a load
//   REG_AW  5  register address width; register 0 is hard-wired zero
// PORTS
//   clk             in   1            clock, rising edge
//   rst             in   1            asynchronous, active-high reset
//   flush           in   1            drop held or incoming bundle (exception/branch redirect)
//   in_valid        in   1            bundle valid from MEM stage
//   in_ready        out  1            stage can accept a bundle this cycle
//   in_lane_vld     in   LANES        per-lane instruction valid
//   in_wen          in   LANES        per-lane writes a register
//   in_wb_sel       in   LANES        1 = load data, 0 = ALU result (ignored for lanes >= 1)
//   in_ld_type      in   3            lane 0 load kind: 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
//   in_addr_lo      in   2            lane 0 load address bits [1:0]
//   in_alu_res      in   LANES*32     per-lane ALU result; lane i in bits [32*i +: 32]
//   in_reg_dst      in   LANES*REG_AW per-lane destination register
//   mem_data_ok     in   1            mem_data valid this cycle
//   mem_data        in   32           word-aligned read data, little-endian
//   wb_w_en         out  LANES        regfile write enable, registered
//   wb_w_reg_addr   out  LANES*REG_AW regfile write address, registered
//   wb_w_data       out  LANES*32     regfile write data, registered
// BEHAVIOUR
//   Reset
//   - Async, rst=1: state=IDLE, wb_w_en=0, wb_w_reg_addr=0, wb_w_data=0, internal regs=0.
//   Handshake and state machine
//   - in_ready = (state==IDLE). A bundle is accepted (fire) when in_valid & in_ready & ~flush.
//   - A lane is live when it is valid, writes a register, and its destination is not register 0:
//       live[i] = in_lane_vld[i] & in_wen[i] & (in_reg_dst[i] != 0).
//   - IDLE, fire with no lane-0 load, or with the load and mem_data_ok=1 in the same cycle:
//     next cycle wb_w_en = live mask; state stays IDLE. Latency is 1 cycle.
//   - IDLE, fire with a lane-0 load and mem_data_ok=0:
//     capture the bundle; state -> WAIT_MEM; wb_w_en = 0.
//   - WAIT_MEM, mem_data_ok=1: capture mem_data; next cycle wb_w_en = the captured live mask
//     (all lanes retire together); state -> IDLE.
//   - WAIT_MEM, mem_data_ok=0: hold; in_ready=0; wb_w_en=0.
//   - No fire: wb_w_en=0 next cycle. Addr and data outputs hold their last values.
//   - wb_w_en is a 1-cycle pulse per retired bundle. It never repeats for the same bundle.
//   Flush
//   - Any state: next cycle wb_w_en=0; state -> IDLE; the pending bundle is discarded.
//   - A mem_data_ok arriving in the same cycle as the flush is ignored.
//   - Flush overrides both mem_data_ok and fire.
//   - Flush does not suppress a write already registered on the outputs.
//   Load extension (lane 0, wb_sel=1)
//   - LB/LBU: byte = mem_data[8*addr_lo +: 8]; sign-extend for LB, zero-extend for LBU.
//   - LH/LHU: half = mem_data[16*addr_lo[1] +: 16]; sign-extend for LH, zero-extend for LHU.
//   - LW, and ld_type 101..111: the full word. addr_lo[0] is ignored for halves.
//   - No misalignment check; that is done upstream.
//   WAW masking
//   - If lanes i < j are both live with equal wb_w_reg_addr, wb_w_en[i] is forced to 0.
//   - The highest lane (youngest instruction) wins.
//   Clocking
//   - wb_sel for lanes >= 1 is treated as 0.
//   - All outputs are registered; there are no combinational paths from inputs to outputs
//     except to in_ready, which depends only on state.
// TESTING
//   1. LANES=2; lane0 dst=3 alu=0x11, lane1 dst=4 alu=0x22, fire
//      -> next cycle wb_w_en=2'b11, addr 3/4, data 0x11/0x22.
//   2. Lane0 LB, addr_lo=2, mem_data=0x0080FF00, ok=1 at fire
//      -> next cycle lane0 data 0xFFFFFF80. With LBU -> 0x00000080.
//   3. Lane0 LH, addr_lo=2, mem_data ok 3 cycles after fire = 0x8001_1234
//      -> in_ready=0 for 3 cycles, then wb_w_en pulse with data 0xFFFF8001, in_ready=1.
//   4. Both lanes live with dst=5 (data 0xA, 0xB) -> wb_w_en=2'b10, lane1 writes 0xB.
//      A dst=0 lane -> its wb_w_en stays 0.
//   5. WAIT_MEM, flush=1 together with mem_data_ok=1
//      -> no write pulse, state IDLE, in_ready=1 next cycle.
//      A later mem_data_ok causes no write.
//   6. rst asserted while in WAIT_MEM
//      -> outputs 0 immediately (async), in_ready=1 after release, no stale write.

Source files
------------

// File: rtl/wbu_pipe.sv
// Multi-lane writeback stage: selects ALU or extended load data per lane, drives the regfile write ports.
// Latency: 1 cycle from accept to write; a lane-0 load without data waits in WAIT_MEM until mem_data_ok.
// Backpressure: in_ready is low only in WAIT_MEM; flush drops the pending bundle and reopens the stage.
module wbu_pipe #(
    parameter int LANES  = 2,
    parameter int REG_AW = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_vld,
    input  logic [LANES-1:0]          in_wen,
    input  logic [LANES-1:0]          in_wb_sel,
    input  logic [2:0]                in_ld_type,
    input  logic [1:0]                in_addr_lo,
    input  logic [LANES*32-1:0]       in_alu_res,
    input  logic [LANES*REG_AW-1:0]   in_reg_dst,
    input  logic                      mem_data_ok,
    input  logic [31:0]               mem_data,
    output logic [LANES-1:0]          wb_w_en,
    output logic [LANES*REG_AW-1:0]   wb_w_reg_addr,
    output logic [LANES*32-1:0]       wb_w_data
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    typedef struct packed {
        logic [LANES-1:0]        live;
        logic [LANES*REG_AW-1:0] dst;
        logic [LANES*32-1:0]     alu;
        logic [2:0]              ld_type;
        logic [1:0]              addr_lo;
        logic                    is_ld;
    } bundle_t;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    state_t                  state_q, state_d;
    bundle_t                 hold_q, hold_d;
    logic [LANES-1:0]        wb_w_en_q, wb_w_en_d;
    logic [LANES*REG_AW-1:0] wb_w_reg_addr_q, wb_w_reg_addr_d;
    logic [LANES*32-1:0]     wb_w_data_q, wb_w_data_d;

    bundle_t                 in_bdl;
    bundle_t                 ret_bdl;
    logic                    fire;
    logic                    retire;

    // Lanes >= 1 never carry loads, so their wb_sel bits are intentionally dropped.
    generate
        if (LANES > 1) begin : g_unused_sel
            logic unused_wb_sel;
            assign unused_wb_sel = ^in_wb_sel[LANES-1:1];
        end
    endgenerate

    function automatic logic [31:0] load_ext(
        input logic [2:0]  ld_type,
        input logic [1:0]  addr_lo,
        input logic [31:0] word
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = word[8*addr_lo +: 8];
        half_v = word[16*addr_lo[1] +: 16];
        case (ld_type)
            LD_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  load_ext = {24'h0, byte_v};
            LD_LH:   load_ext = {{16{half_v[15]}}, half_v};
            LD_LHU:  load_ext = {16'h0, half_v};
            default: load_ext = word;
        endcase
    endfunction

    // Older lane loses when a younger live lane targets the same register.
    function automatic logic [LANES-1:0] waw_mask(
        input logic [LANES-1:0]        live,
        input logic [LANES*REG_AW-1:0] dst
    );
        waw_mask = live;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (live[i] && live[j] &&
                    (dst[i*REG_AW +: REG_AW] == dst[j*REG_AW +: REG_AW])) begin
                    waw_mask[i] = 1'b0;
                end
            end
        end
    endfunction

    always_comb begin
        in_bdl         = '0;
        in_bdl.dst     = in_reg_dst;
        in_bdl.alu     = in_alu_res;
        in_bdl.ld_type = in_ld_type;
        in_bdl.addr_lo = in_addr_lo;
        in_bdl.is_ld   = in_lane_vld[0] & in_wb_sel[0];
        for (int i = 0; i < LANES; i++) begin
            in_bdl.live[i] = in_lane_vld[i] & in_wen[i] &
                             (in_reg_dst[i*REG_AW +: REG_AW] != '0);
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign fire     = in_valid & in_ready & ~flush;

    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        wb_w_en_d       = '0;
        wb_w_reg_addr_d = wb_w_reg_addr_q;
        wb_w_data_d     = wb_w_data_q;
        retire          = 1'b0;
        ret_bdl         = in_bdl;

        // Flush wins over both an incoming bundle and late memory data.
        if (flush) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire) begin
                        if (in_bdl.is_ld && !mem_data_ok) begin
                            hold_d  = in_bdl;
                            state_d = ST_WAIT_MEM;
                        end else begin
                            retire  = 1'b1;
                            ret_bdl = in_bdl;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_data_ok) begin
                        retire  = 1'b1;
                        ret_bdl = hold_q;
                        hold_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (retire) begin
            wb_w_en_d       = waw_mask(ret_bdl.live, ret_bdl.dst);
            wb_w_reg_addr_d = ret_bdl.dst;
            wb_w_data_d     = ret_bdl.alu;
            if (ret_bdl.is_ld) begin
                wb_w_data_d[31:0] = load_ext(ret_bdl.ld_type, ret_bdl.addr_lo, mem_data);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            hold_q          <= '0;
            wb_w_en_q       <= '0;
            wb_w_reg_addr_q <= '0;
            wb_w_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            wb_w_en_q       <= wb_w_en_d;
            wb_w_reg_addr_q <= wb_w_reg_addr_d;
            wb_w_data_q     <= wb_w_data_d;
        end
    end

    assign wb_w_en       = wb_w_en_q;
    assign wb_w_reg_addr = wb_w_reg_addr_q;
    assign wb_w_data     = wb_w_data_q;

endmodule

// File: tb/tb_wbu_pipe.sv
// Directed bench for wbu_pipe (LANES=2, REG_AW=5) with immediate-assertion checks.
module tb_wbu_pipe;

    localparam int LANES  = 2;
    localparam int REG_AW = 5;

    logic                    clk;
    logic                    rst;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        in_lane_vld;
    logic [LANES-1:0]        in_wen;
    logic [LANES-1:0]        in_wb_sel;
    logic [2:0]              in_ld_type;
    logic [1:0]              in_addr_lo;
    logic [LANES*32-1:0]     in_alu_res;
    logic [LANES*REG_AW-1:0] in_reg_dst;
    logic                    mem_data_ok;
    logic [31:0]             mem_data;
    logic [LANES-1:0]        wb_w_en;
    logic [LANES*REG_AW-1:0] wb_w_reg_addr;
    logic [LANES*32-1:0]     wb_w_data;

    int checks   = 0;
    int failures = 0;

    wbu_pipe #(.LANES(LANES), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_lane_vld   (in_lane_vld),
        .in_wen        (in_wen),
        .in_wb_sel     (in_wb_sel),
        .in_ld_type    (in_ld_type),
        .in_addr_lo    (in_addr_lo),
        .in_alu_res    (in_alu_res),
        .in_reg_dst    (in_reg_dst),
        .mem_data_ok   (mem_data_ok),
        .mem_data      (mem_data),
        .wb_w_en       (wb_w_en),
        .wb_w_reg_addr (wb_w_reg_addr),
        .wb_w_data     (wb_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [1:0] vld, input logic [1:0] wen, input logic [1:0] sel,
                          input logic [2:0] ldt, input logic [1:0] alo,
                          input logic [4:0] d0, input logic [31:0] a0,
                          input logic [4:0] d1, input logic [31:0] a1);
        in_valid    = 1'b1;
        in_lane_vld = vld;
        in_wen      = wen;
        in_wb_sel   = sel;
        in_ld_type  = ldt;
        in_addr_lo  = alo;
        in_reg_dst  = {d1, d0};
        in_alu_res  = {a1, a0};
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        flush       = 1'b0;
        mem_data_ok = 1'b0;
        in_lane_vld = '0;
        in_wen      = '0;
        in_wb_sel   = '0;
        in_ld_type  = '0;
        in_addr_lo  = '0;
        in_reg_dst  = '0;
        in_alu_res  = '0;
        mem_data    = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("reset_en", 64'(wb_w_en), 64'h0);
        check("reset_addr", 64'(wb_w_reg_addr), 64'h0);
        check("reset_data", 64'(wb_w_data), 64'h0);
        check("reset_ready", 64'(in_ready), 64'h1);
        rst = 1'b0;
        step();

        // Two independent ALU lanes
        bundle(2'b11, 2'b11, 2'b00, 3'd0, 2'd0, 5'd3, 32'h11, 5'd4, 32'h22);
        step();
        idle_inputs();
        check("alu2_en", 64'(wb_w_en), 64'h3);
        check("alu2_addr", 64'(wb_w_reg_addr), 64'({5'd4, 5'd3}));
        check("alu2_data", 64'(wb_w_data), {32'h22, 32'h11});
        step();
        check("alu2_pulse_once", 64'(wb_w_en), 64'h0);
        check("alu2_addr_hold", 64'(wb_w_reg_addr), 64'({5'd4, 5'd3}));

        // LB with data on time, byte 2 of 0x0080FF00 = 0x80
        bundle(2'b01, 2'b01, 2'b01, 3'b001, 2'd2, 5'd7, 32'hDEAD, 5'd0, 32'h0);
        mem_data_ok = 1'b1;
        mem_data    = 32'h0080FF00;
        check("ready_idle", 64'(in_ready), 64'h1);
        step();
        idle_inputs();
        check("lb_en", 64'(wb_w_en), 64'h1);
        check("lb_data", 64'(wb_w_data[31:0]), 64'hFFFFFF80);

        bundle(2'b01, 2'b01, 2'b01, 3'b010, 2'd2, 5'd7, 32'hDEAD, 5'd0, 32'h0);
        mem_data_ok = 1'b1;
        mem_data    = 32'h0080FF00;
        step();
        idle_inputs();
        check("lbu_data", 64'(wb_w_data[31:0]), 64'h00000080);

        // LHU with addr_lo=1: bit 0 ignored, low half zero-extended
        bundle(2'b01, 2'b01, 2'b01, 3'b100, 2'd1, 5'd2, 32'h0, 5'd0, 32'h0);
        mem_data_ok = 1'b1;
        mem_data    = 32'h80019234;
        step();
        idle_inputs();
        check("lhu_data", 64'(wb_w_data[31:0]), 64'h00009234);

        // LH with memory data three cycles late; inputs scrambled meanwhile
        bundle(2'b11, 2'b11, 2'b01, 3'b011, 2'd2, 5'd9, 32'h0, 5'd10, 32'h55);
        step();
        bundle(2'b11, 2'b11, 2'b00, 3'd0, 2'd0, 5'd20, 32'h99, 5'd21, 32'h77);
        check("lh_wait_ready1", 64'(in_ready), 64'h0);
        check("lh_wait_en1", 64'(wb_w_en), 64'h0);
        step();
        check("lh_wait_ready2", 64'(in_ready), 64'h0);
        step();
        check("lh_wait_ready3", 64'(in_ready), 64'h0);
        check("lh_wait_en3", 64'(wb_w_en), 64'h0);
        mem_data_ok = 1'b1;
        mem_data    = 32'h80011234;
        step();
        idle_inputs();
        check("lh_en", 64'(wb_w_en), 64'h3);
        check("lh_addr", 64'(wb_w_reg_addr), 64'({5'd10, 5'd9}));
        check("lh_data", 64'(wb_w_data), {32'h55, 32'hFFFF8001});
        check("lh_ready_after", 64'(in_ready), 64'h1);
        step();
        check("lh_no_repeat", 64'(wb_w_en), 64'h0);

        // WAW: same destination, younger lane wins
        bundle(2'b11, 2'b11, 2'b00, 3'd0, 2'd0, 5'd5, 32'hA, 5'd5, 32'hB);
        step();
        idle_inputs();
        check("waw_en", 64'(wb_w_en), 64'h2);
        check("waw_data1", 64'(wb_w_data[63:32]), 64'hB);

        bundle(2'b11, 2'b11, 2'b00, 3'd0, 2'd0, 5'd0, 32'hC, 5'd6, 32'hD);
        step();
        idle_inputs();
        check("r0_en", 64'(wb_w_en), 64'h2);

        // Flush together with late data drops the held load
        bundle(2'b01, 2'b01, 2'b01, 3'b000, 2'd0, 5'd8, 32'h0, 5'd0, 32'h0);
        step();
        idle_inputs();
        check("fl_wait_ready", 64'(in_ready), 64'h0);
        flush       = 1'b1;
        mem_data_ok = 1'b1;
        mem_data    = 32'h12345678;
        step();
        idle_inputs();
        check("fl_en", 64'(wb_w_en), 64'h0);
        check("fl_ready", 64'(in_ready), 64'h1);
        mem_data_ok = 1'b1;
        mem_data    = 32'hCAFEF00D;
        step();
        idle_inputs();
        check("fl_late_ok_en", 64'(wb_w_en), 64'h0);

        // Flush overrides fire; flush does not cancel an already registered write
        bundle(2'b01, 2'b01, 2'b00, 3'd0, 2'd0, 5'd12, 32'h1, 5'd0, 32'h0);
        flush = 1'b1;
        step();
        idle_inputs();
        check("fl_fire_en", 64'(wb_w_en), 64'h0);
        bundle(2'b01, 2'b01, 2'b00, 3'd0, 2'd0, 5'd13, 32'h2, 5'd0, 32'h0);
        step();
        idle_inputs();
        flush = 1'b1;
        #1;
        check("fl_keeps_reg_en", 64'(wb_w_en), 64'h1);
        step();
        idle_inputs();
        check("fl_after_reg_en", 64'(wb_w_en), 64'h0);

        // Async reset while waiting for memory
        bundle(2'b01, 2'b01, 2'b01, 3'b000, 2'd0, 5'd14, 32'h0, 5'd0, 32'h0);
        step();
        idle_inputs();
        check("rst_wait_ready", 64'(in_ready), 64'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_en", 64'(wb_w_en), 64'h0);
        check("rst_async_addr", 64'(wb_w_reg_addr), 64'h0);
        check("rst_async_data", 64'(wb_w_data), 64'h0);
        check("rst_async_ready", 64'(in_ready), 64'h1);
        step();
        rst = 1'b0;
        mem_data_ok = 1'b1;
        mem_data    = 32'h87654321;
        step();
        idle_inputs();
        check("rst_no_stale_en", 64'(wb_w_en), 64'h0);
        check("rst_ready_after", 64'(in_ready), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
